// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle control sequencer: state encoding
// and the legal range of the data-memory wait parameter.
package seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEMORY    = 4'd4,
    S_WRITEBACK = 4'd5,
    S_COMMIT    = 4'd6,
    S_PAUSE     = 4'd7,
    S_HALT      = 4'd8
  } state_t;

  localparam int MEM_WAIT_MIN = 1;
  localparam int MEM_WAIT_MAX = 3;

  // Out-of-range wait values are pulled into the legal window.
  function automatic int clamp_mem_wait(input int w);
    if (w < MEM_WAIT_MIN) return MEM_WAIT_MIN;
    if (w > MEM_WAIT_MAX) return MEM_WAIT_MAX;
    return w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: walks each instruction through
// FETCH..COMMIT, with single-step pausing and a terminal HALT state.
module multicycle_sequencer #(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_op,
  input  logic             we1_req,
  input  logic             we2_req,
  input  logic             is_load,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             step_ack,
  output logic             ir_en,
  output logic             rf_we,
  output logic             dm_we,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);
  import seq_pkg::*;

  localparam int         WAIT_EFF  = clamp_mem_wait(MEM_WAIT);
  localparam logic [1:0] WAIT_LAST = 2'(WAIT_EFF - 1);

  state_t     cur, nxt;
  logic       f_halt, f_we1, f_store, f_load;
  logic       armed;
  logic [1:0] mem_cnt;
  logic       ack;

  // Handshake: step_req is a level held by the requester; step_ack is
  // high for exactly the PAUSE cycle in which the step is taken, and a
  // new step needs step_req to be seen low first (armed).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur     <= S_IDLE;
      f_halt  <= 1'b0;
      f_we1   <= 1'b0;
      f_store <= 1'b0;
      f_load  <= 1'b0;
      armed   <= 1'b1;
      mem_cnt <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        f_halt  <= halt_op;
        f_we1   <= we1_req;
        f_store <= we2_req;
        f_load  <= is_load & ~we2_req;
      end
      if (cur == S_EXECUTE) begin
        mem_cnt <= WAIT_LAST;
      end else if ((cur == S_MEMORY) && (mem_cnt != 2'd0)) begin
        mem_cnt <= mem_cnt - 2'd1;
      end
      if (ack) begin
        armed <= 1'b0;
      end else if (!step_req) begin
        armed <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt = cur;
    ack = 1'b0;
    case (cur)
      S_IDLE:      if (start) nxt = S_FETCH;
      S_FETCH:     nxt = S_DECODE;
      S_DECODE:    nxt = halt_op ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (f_store || f_load) nxt = S_MEMORY;
        else if (f_we1)        nxt = S_WRITEBACK;
        else                   nxt = S_COMMIT;
      end
      S_MEMORY:    if (mem_cnt == 2'd0) nxt = f_load ? S_WRITEBACK : S_COMMIT;
      S_WRITEBACK: nxt = S_COMMIT;
      S_COMMIT:    nxt = step_mode ? S_PAUSE : S_FETCH;
      S_PAUSE: begin
        if (step_req && armed) begin
          ack = 1'b1;
          nxt = S_FETCH;
        end
      end
      S_HALT:      nxt = S_HALT;
      default:     nxt = S_IDLE;
    endcase
  end

  // Strobes depend only on registered state; a latched halt masks them.
  always_comb begin
    ir_en    = (cur == S_FETCH);
    rf_we    = (cur == S_WRITEBACK) && !f_halt;
    pc_en    = (cur == S_COMMIT) && !f_halt;
    dm_we    = (cur == S_MEMORY) && f_store && (mem_cnt == WAIT_LAST);
    busy     = (cur != S_IDLE) && (cur != S_PAUSE) && (cur != S_HALT);
    halted   = (cur == S_HALT);
    step_ack = ack;
    state    = cur;
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_retired (
    .clk  (clk),
    .reset(reset),
    .en   (cur == S_COMMIT),
    .count(instr_count)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer with MEM_WAIT=2 and a 4-bit retired counter:
// vector table, randomized instructions against a latency model, corner sequences.
module tb_multicycle_sequencer;

  localparam int MW      = 2;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXECUTE = 3,
                 ST_MEMORY = 4, ST_WB = 5, ST_COMMIT = 6, ST_PAUSE = 7, ST_HALT = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, halt_op = 1'b0, we1_req = 1'b0, we2_req = 1'b0;
  logic          is_load = 1'b0, step_mode = 1'b0, step_req = 1'b0;
  logic          step_ack, ir_en, rf_we, dm_we, pc_en, busy, halted;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic  h, w1, w2, ld;
    int    cyc, rf, dm;
    string name;
  } vec_t;
  vec_t vecs[8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  multicycle_sequencer #(
    .MEM_WAIT(MW),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_op    (halt_op),
    .we1_req    (we1_req),
    .we2_req    (we2_req),
    .is_load    (is_load),
    .step_mode  (step_mode),
    .step_req   (step_req),
    .step_ack   (step_ack),
    .ir_en      (ir_en),
    .rf_we      (rf_we),
    .dm_we      (dm_we),
    .pc_en      (pc_en),
    .busy       (busy),
    .halted     (halted),
    .state      (state),
    .instr_count(instr_count)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int strobe_sum();
    return int'(ir_en) + int'(rf_we) + int'(dm_we) + int'(pc_en);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_state"}, int'(state), ST_IDLE);
    check({tag, "_strobes"}, strobe_sum(), 0);
    check({tag, "_flags"}, int'(busy) + int'(halted) + int'(step_ack), 0);
    check({tag, "_count"}, int'(instr_count), 0);
  endtask

  // Reference model: instruction class decides the path and latency.
  function automatic void model_instr(input logic w1, input logic w2, input logic ld,
                                      output int cyc, output int rf, output int dm);
    bit st, lo, alu;
    st  = w2;
    lo  = ld && !w2;
    alu = w1 && !st && !lo;
    rf  = (lo || alu) ? 1 : 0;
    dm  = st ? 1 : 0;
    cyc = 4 + ((st || lo) ? MW : 0) + rf;
    exp_q.delete();
    exp_q.push_back(4'(ST_FETCH));
    exp_q.push_back(4'(ST_DECODE));
    exp_q.push_back(4'(ST_EXECUTE));
    if (st || lo) for (int i = 0; i < MW; i++) exp_q.push_back(4'(ST_MEMORY));
    if (rf == 1) exp_q.push_back(4'(ST_WB));
    exp_q.push_back(4'(ST_COMMIT));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; halt_op = 1'b0; we1_req = 1'b0; we2_req = 1'b0;
    is_load = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    #1 check_zero(tag);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_cnt = 0;
  endtask

  task automatic start_run(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start"}, int'(state), ST_FETCH);
  endtask

  // Runs one non-halt instruction from FETCH to the next FETCH or PAUSE.
  task automatic run_instr(input logic w1, input logic w2, input logic ld,
                           input int exp_cyc, input int exp_rf, input int exp_dm,
                           input string tag);
    int cyc, rf_n, dm_n, pc_n, ir_n, dm_at, m_cyc, m_rf, m_dm;
    logic [3:0] exp_s;
    halt_op = 1'b0; we1_req = w1; we2_req = w2; is_load = ld;
    model_instr(w1, w2, ld, m_cyc, m_rf, m_dm);
    check({tag, "_entry"}, int'(state), ST_FETCH);
    cyc = 0; rf_n = 0; dm_n = 0; pc_n = 0; ir_n = 0; dm_at = -1;
    do begin
      if (exp_q.size() > 0) begin
        exp_s = exp_q.pop_front();
        check({tag, "_seq"}, int'(state), int'(exp_s));
      end else begin
        check({tag, "_extra_state"}, int'(state), -1);
      end
      check({tag, "_busy"}, int'(busy), 1);
      rf_n += int'(rf_we); pc_n += int'(pc_en); ir_n += int'(ir_en);
      if (dm_we) begin dm_n++; dm_at = cyc; end
      cyc++;
      @(negedge clk);
    end while (state != 4'(ST_FETCH) && state != 4'(ST_PAUSE) && cyc < 20);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_model_cycles"}, cyc, m_cyc);
    check({tag, "_rf_we"}, rf_n, exp_rf);
    check({tag, "_dm_we"}, dm_n, exp_dm);
    check({tag, "_pc_en"}, pc_n, 1);
    check({tag, "_ir_en"}, ir_n, 1);
    check({tag, "_seq_left"}, exp_q.size(), 0);
    if (exp_dm == 1) check({tag, "_dm_first_mem"}, dm_at, 3);
    model_cnt = (model_cnt < CNT_MAX) ? model_cnt + 1 : CNT_MAX;
    check({tag, "_count"}, int'(instr_count), model_cnt);
  endtask

  // ---------------- test ----------------
  initial begin
    int acks, cyc, r_cyc, r_rf, r_dm;
    logic w1, w2, ld;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 5, 1, 0, "alu"};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 0, 0, "nop"};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 6, 0, 1, "store"};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 7, 1, 0, "load"};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 6, 0, 1, "store_load"};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 6, 0, 1, "store_we1"};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 7, 1, 0, "load_we1"};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 6, 0, 1, "all_flags"};

    #1 check_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_wait", int'(state), ST_IDLE);

    start_run("tbl");
    foreach (vecs[i])
      run_instr(vecs[i].w1, vecs[i].w2, vecs[i].ld, vecs[i].cyc, vecs[i].rf, vecs[i].dm,
                vecs[i].name);

    for (int i = 0; i < 12; i++) begin
      w1 = 1'($urandom_range(0, 1));
      w2 = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
      model_instr(w1, w2, ld, r_cyc, r_rf, r_dm);
      run_instr(w1, w2, ld, r_cyc, r_rf, r_dm, "rnd");
    end

    // Saturation: 17 ALU ops on a 4-bit counter.
    apply_reset("rst_sat");
    start_run("sat");
    for (int i = 0; i < 17; i++) run_instr(1'b1, 1'b0, 1'b0, 5, 1, 0, "sat_alu");
    check("sat_value", int'(instr_count), 15);

    // Single step with step_req held high.
    apply_reset("rst_step");
    start_run("step");
    step_mode = 1'b1;
    run_instr(1'b1, 1'b0, 1'b0, 5, 1, 0, "step_first");
    check("step_in_pause", int'(state), ST_PAUSE);
    check("step_pause_busy", int'(busy), 0);
    halt_op = 1'b0; we1_req = 1'b0; we2_req = 1'b0; is_load = 1'b0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step_req = 1'b1;
      #1 acks += int'(step_ack);
      @(negedge clk);
    end
    check("step_ack_count", acks, 1);
    check("step_back_in_pause", int'(state), ST_PAUSE);
    model_cnt = (model_cnt < CNT_MAX) ? model_cnt + 1 : CNT_MAX;
    check("step_count", int'(instr_count), model_cnt);
    step_req = 1'b0;
    step_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("pause_no_step", int'(state), ST_PAUSE);
    step_req = 1'b1;
    #1 check("step_ack_again", int'(step_ack), 1);
    @(negedge clk);
    step_req = 1'b0;
    check("step_resume", int'(state), ST_FETCH);
    run_instr(1'b0, 1'b0, 1'b1, 7, 1, 0, "after_step");
    check("free_run", int'(state), ST_FETCH);

    // Asynchronous reset in the middle of a load.
    apply_reset("rst_mid");
    start_run("mid");
    is_load = 1'b1;
    cyc = 0;
    while (state != 4'(ST_MEMORY) && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reach_memory", int'(state), ST_MEMORY);
    #2 reset = 1'b0;
    #1 check_zero("mid_async");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_stays_idle", int'(state), ST_IDLE);
      check("mid_no_strobe", strobe_sum(), 0);
    end
    is_load = 1'b0;

    // HALT is terminal and ignores start.
    start_run("halt");
    run_instr(1'b1, 1'b0, 1'b0, 5, 1, 0, "pre_halt");
    halt_op = 1'b1;
    @(negedge clk);
    check("halt_decode", int'(state), ST_DECODE);
    @(negedge clk);
    check("halt_state", int'(state), ST_HALT);
    check("halt_halted", int'(halted), 1);
    check("halt_busy", int'(busy), 0);
    halt_op = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = (i % 2 == 0);
      @(negedge clk);
      check("halt_hold", int'(state), ST_HALT);
      check("halt_no_strobe", strobe_sum(), 0);
      check("halt_count", int'(instr_count), model_cnt);
    end
    start = 1'b0;
    apply_reset("rst_halt");
    @(negedge clk);
    check("halt_reset_idle", int'(state), ST_IDLE);
    check("halt_reset_halted", int'(halted), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
